// File: rtl/ber_pkg.sv
// Shared types and constants for the BER pattern generator: pattern selects, LFSR taps,
// control states and small helpers.
package ber_pkg;

  localparam int unsigned LfsrWidth = 23;

  typedef enum logic [1:0] {
    PrbsSel7   = 2'd0,
    PrbsSel15  = 2'd1,
    PrbsSel23  = 2'd2,
    PrbsSelAlt = 2'd3
  } prbs_sel_e;

  localparam int unsigned Prbs7TapHi  = 6;
  localparam int unsigned Prbs7TapLo  = 5;
  localparam int unsigned Prbs15TapHi = 14;
  localparam int unsigned Prbs15TapLo = 13;
  localparam int unsigned Prbs23TapHi = 22;
  localparam int unsigned Prbs23TapLo = 17;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StTail,
    StDone
  } state_e;

  function automatic logic [LfsrWidth-1:0] seed_mask(prbs_sel_e sel);
    logic [LfsrWidth-1:0] mask;
    case (sel)
      PrbsSel7:  mask = 23'h00007F;
      PrbsSel15: mask = 23'h007FFF;
      PrbsSel23: mask = 23'h7FFFFF;
      default:   mask = '0;
    endcase
    return mask;
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by all-ones of the active width.
  // The alternating pattern ignores the seed and always starts from zero state.
  function automatic logic [LfsrWidth-1:0] seed_init(prbs_sel_e sel, logic [LfsrWidth-1:0] seed);
    logic [LfsrWidth-1:0] mask;
    logic [LfsrWidth-1:0] s;
    mask = seed_mask(sel);
    s    = seed & mask;
    if (s == '0) s = mask;
    return s;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ber_pattern_gen_if.sv
// Encoder-side symbol handshake plus the clean reference stream for the BER checker.
interface ber_pattern_gen_if;
  logic tx_valid;
  logic tx_bit;
  logic tx_ready;
  logic ref_valid;
  logic ref_bit;
  logic advance;

  modport master (
    output tx_valid, tx_bit, ref_valid, ref_bit, advance,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_bit, ref_valid, ref_bit, advance,
    output tx_ready
  );
endinterface

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR with selectable polynomial; bit_o is the feedback of the current state and
// becomes the new bit 0 on step.
module prbs_lfsr
  import ber_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LfsrWidth-1:0] seed_i,
  input  prbs_sel_e            sel_i,
  input  logic                 step_i,
  output logic                 bit_o
);

  logic [LfsrWidth-1:0] state_q, state_d;
  prbs_sel_e            sel_q, sel_d;
  logic                 fb;

  // Alternating mode reuses the shifter: feeding back ~bit0 yields 1,0,1,0 from zero state.
  always_comb begin
    fb = 1'b0;
    unique case (sel_q)
      PrbsSel7:   fb = state_q[Prbs7TapHi] ^ state_q[Prbs7TapLo];
      PrbsSel15:  fb = state_q[Prbs15TapHi] ^ state_q[Prbs15TapLo];
      PrbsSel23:  fb = state_q[Prbs23TapHi] ^ state_q[Prbs23TapLo];
      PrbsSelAlt: fb = ~state_q[0];
      default:    fb = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (load_i) begin
      sel_d   = sel_i;
      state_d = seed_init(sel_i, seed_i);
    end else if (step_i) begin
      state_d = {state_q[LfsrWidth-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      sel_q   <= PrbsSel7;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign bit_o = fb;

endmodule

// File: rtl/ber_pattern_gen.sv
// BER test stimulus source: PRBS payload with optional periodic bit flips, zero tail to
// flush the decoder, and a clean reference stream for the receive-side checker.
module ber_pattern_gen
  import ber_pkg::*;
#(
  parameter int unsigned TbLen = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [15:0]           total_bits_i,
  input  logic [1:0]            prbs_sel_i,
  input  logic [LfsrWidth-1:0]  seed_i,
  input  logic [15:0]           err_interval_i,
  ber_pattern_gen_if.master     tx_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           bits_sent_o,
  output logic [31:0]           errors_injected_o
);

  localparam int unsigned TailW = (TbLen > 1) ? $clog2(TbLen) : 1;

  state_e           state_q, state_d;
  logic [15:0]      total_q, total_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [TailW-1:0] tail_q, tail_d;
  logic [31:0]      bits_q, bits_d;
  logic [31:0]      errs_q, errs_d;

  logic in_payload, in_tail, tx_valid, xfer, flip_now, start_ok, lfsr_bit;

  assign in_payload = (state_q == StPayload);
  assign in_tail    = (state_q == StTail);
  assign tx_valid   = in_payload | in_tail;
  assign xfer       = tx_valid & tx_if.tx_ready;
  assign start_ok   = start_i & ((state_q == StIdle) | (state_q == StDone));

  // Flip the bit whose transfer brings the interval count up to err_interval.
  assign flip_now = in_payload && (err_q != 16'd0) &&
                    (({1'b0, cnt_q} + 17'd1) == {1'b0, err_q});

  prbs_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (start_ok),
    .seed_i (seed_i),
    .sel_i  (prbs_sel_e'(prbs_sel_i)),
    .step_i (in_payload & xfer),
    .bit_o  (lfsr_bit)
  );

  assign tx_if.tx_valid  = tx_valid;
  assign tx_if.tx_bit    = in_payload & (lfsr_bit ^ flip_now);
  assign tx_if.ref_valid = in_payload & tx_if.tx_ready;
  assign tx_if.ref_bit   = in_payload & lfsr_bit;
  assign tx_if.advance   = xfer;

  assign busy_o            = tx_valid;
  assign done_o            = (state_q == StDone);
  assign bits_sent_o       = bits_q;
  assign errors_injected_o = errs_q;

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    bits_d  = bits_q;
    errs_d  = errs_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          total_d = total_bits_i;
          err_d   = err_interval_i;
          cnt_d   = '0;
          tail_d  = '0;
          bits_d  = '0;
          errs_d  = '0;
          state_d = (total_bits_i == 16'd0) ? StDone : StPayload;
        end
      end
      StPayload: begin
        if (xfer) begin
          bits_d = sat_inc(bits_q);
          if (flip_now) begin
            cnt_d  = '0;
            errs_d = sat_inc(errs_q);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
          if ((bits_q + 32'd1) == {16'd0, total_q}) state_d = StTail;
        end
      end
      StTail: begin
        if (xfer) begin
          if (tail_q == TailW'(TbLen - 1)) state_d = StDone;
          else tail_d = tail_q + TailW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      total_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      bits_q  <= '0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      bits_q  <= bits_d;
      errs_q  <= errs_d;
    end
  end

endmodule

// File: tb/tb_ber_pattern_gen.sv
// Directed and randomized checks of ber_pattern_gen against a recurrence-based PRBS model.
module tb_ber_pattern_gen;

  localparam int TbLen = 12;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] total_bits;
  logic [1:0]  prbs_sel;
  logic [22:0] seed;
  logic [15:0] err_interval;
  logic        busy;
  logic        done;
  logic [31:0] bits_sent;
  logic [31:0] errors_injected;

  ber_pattern_gen_if tx_if ();

  ber_pattern_gen #(.TbLen(TbLen)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start),
    .total_bits_i      (total_bits),
    .prbs_sel_i        (prbs_sel),
    .seed_i            (seed),
    .err_interval_i    (err_interval),
    .tx_if             (tx_if.master),
    .busy_o            (busy),
    .done_o            (done),
    .bits_sent_o       (bits_sent),
    .errors_injected_o (errors_injected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit exp_q[$];
  bit tx_q[$];
  bit ref_q[$];
  int n_adv, n_refv, hold_viol, adv_viol, done_cycle;
  bit finished, first_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output o[n] = o[n-1-ta] ^ o[n-1-tb]; the seed supplies o[-1-j] = seed[j].
  task automatic build_model(input int sel, input logic [22:0] sd, input int n);
    int w, ta, tb, idx;
    logic [22:0] m, s;
    bit h[$];
    exp_q.delete();
    if (sel == 3) begin
      for (int i = 0; i < n; i++) exp_q.push_back(i % 2 == 0);
    end else begin
      w  = (sel == 0) ? 7 : (sel == 1) ? 15 : 23;
      ta = w - 1;
      tb = (sel == 2) ? 17 : w - 2;
      m  = '0;
      for (int j = 0; j < w; j++) m[j] = 1'b1;
      s = sd & m;
      if (s == '0) s = m;
      for (int j = w - 1; j >= 0; j--) h.push_back(s[j]);
      for (int i = 0; i < n; i++) begin
        idx = h.size();
        h.push_back(h[idx-1-ta] ^ h[idx-1-tb]);
        exp_q.push_back(h[idx]);
      end
    end
  endtask

  task automatic do_start(input int sel, input logic [22:0] sd, input int tot, input int ei);
    @(posedge clk); #1;
    prbs_sel     = 2'(sel);
    seed         = sd;
    total_bits   = 16'(tot);
    err_interval = 16'(ei);
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input int budget, input int ready_pct, input int restart_at);
    bit prev_stall, prev_bit, prev_ref;
    tx_q.delete();
    ref_q.delete();
    n_adv = 0; n_refv = 0; hold_viol = 0; adv_viol = 0; done_cycle = -1;
    finished = 0; first_valid = 0; prev_stall = 0; prev_bit = 0; prev_ref = 0;
    for (int c = 0; c < budget; c++) begin
      tx_if.tx_ready = ($urandom_range(99) < ready_pct);
      if (c == restart_at) begin
        start = 1'b1; total_bits = 16'd5; prbs_sel = 2'd3; err_interval = 16'd1; seed = 23'h1;
      end else begin
        start = 1'b0;
      end
      #3;
      if (c == 0) first_valid = tx_if.tx_valid;
      if (done) begin
        finished = 1; done_cycle = c;
        break;
      end
      if (prev_stall && (tx_if.tx_bit !== prev_bit || tx_if.ref_bit !== prev_ref ||
                         tx_if.tx_valid !== 1'b1)) hold_viol++;
      if (tx_if.advance !== (tx_if.tx_valid & tx_if.tx_ready)) adv_viol++;
      if (tx_if.advance) begin n_adv++; tx_q.push_back(tx_if.tx_bit); end
      if (tx_if.ref_valid) begin n_refv++; ref_q.push_back(tx_if.ref_bit); end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_bit   = tx_if.tx_bit;
      prev_ref   = tx_if.ref_bit;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic verify_run(input string tag, input int n, input int ei);
    int ref_mm, tx_mm, tail_nz;
    bit flip;
    ref_mm = 0; tx_mm = 0; tail_nz = 0;
    for (int i = 0; i < ref_q.size() && i < n; i++) if (ref_q[i] !== exp_q[i]) ref_mm++;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i < n) begin
        flip = (ei != 0) && ((i + 1) % ei == 0);
        if (tx_q[i] !== (exp_q[i] ^ flip)) tx_mm++;
      end else if (tx_q[i] !== 1'b0) begin
        tail_nz++;
      end
    end
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " advance count"}, n_adv, (n == 0) ? 0 : n + TbLen);
    check({tag, " ref_valid count"}, n_refv, n);
    check({tag, " ref stream mismatches"}, ref_mm, 0);
    check({tag, " tx stream mismatches"}, tx_mm, 0);
    check({tag, " tail nonzero"}, tail_nz, 0);
    check({tag, " bits_sent"}, bits_sent, n);
    check({tag, " errors_injected"}, errors_injected, (ei == 0) ? 0 : n / ei);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " stall hold"}, hold_viol, 0);
    check({tag, " advance rule"}, adv_viol, 0);
  endtask

  initial begin
    int n, ei, sel;
    logic [22:0] sd;
    logic [31:0] packed7;

    rst = 1'b1; start = 1'b0; total_bits = '0; prbs_sel = '0; seed = '0; err_interval = '0;
    tx_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_valid", 32'(tx_if.tx_valid), 0);
    check("reset tx_bit", 32'(tx_if.tx_bit), 0);
    check("reset ref_valid", 32'(tx_if.ref_valid), 0);
    check("reset ref_bit", 32'(tx_if.ref_bit), 0);
    check("reset advance", 32'(tx_if.advance), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset bits_sent", bits_sent, 0);
    check("reset errors_injected", errors_injected, 0);
    rst = 1'b0;

    // PRBS7 from all-ones seed
    build_model(0, 23'h7F, 7);
    do_start(0, 23'h7F, 7, 0);
    run(200, 100, -1);
    check("prbs7 first valid", 32'(first_valid), 1);
    packed7 = '0;
    for (int i = 0; i < 7 && i < tx_q.size(); i++) packed7 = {packed7[30:0], tx_q[i]};
    check("prbs7 first seven bits", packed7, 32'h1);
    verify_run("prbs7", 7, 0);

    // PRBS15 with every tenth bit flipped
    sd = 23'($urandom);
    build_model(1, sd, 100);
    do_start(1, sd, 100, 10);
    run(500, 100, -1);
    verify_run("prbs15 inject", 100, 10);

    // PRBS23 with random backpressure
    sd = 23'($urandom);
    build_model(2, sd, 1000);
    do_start(2, sd, 1000, 0);
    run(6000, 50, -1);
    verify_run("prbs23 stalls", 1000, 0);

    // Empty payload
    do_start(1, 23'h123, 0, 3);
    run(20, 100, -1);
    check("zero len done cycle", done_cycle, 0);
    check("zero len first valid", 32'(first_valid), 0);
    exp_q.delete();
    verify_run("zero len", 0, 3);

    // Start mid-payload must be ignored
    build_model(0, 23'h0, 50);
    do_start(0, 23'h0, 50, 7);
    run(500, 100, 10);
    verify_run("mid start ignored", 50, 7);

    // Reset in the tail, then a fresh alternating run
    do_start(0, 23'h7F, 5, 0);
    tx_if.tx_ready = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    check("tail busy", 32'(busy), 1);
    check("tail ref_valid", 32'(tx_if.ref_valid), 0);
    check("tail tx_bit", 32'(tx_if.tx_bit), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid rst tx_valid", 32'(tx_if.tx_valid), 0);
    check("mid rst advance", 32'(tx_if.advance), 0);
    check("mid rst busy", 32'(busy), 0);
    check("mid rst done", 32'(done), 0);
    check("mid rst bits_sent", bits_sent, 0);
    rst = 1'b0;
    build_model(3, 23'h0, 4);
    do_start(3, 23'h55, 4, 0);
    run(200, 100, -1);
    packed7 = '0;
    for (int i = 0; i < 4 && i < tx_q.size(); i++) packed7 = {packed7[30:0], tx_q[i]};
    check("alt payload", packed7, 32'hA);
    verify_run("alt after rst", 4, 0);

    // Random configurations
    for (int k = 0; k < 4; k++) begin
      sel = $urandom_range(3);
      sd  = (k == 0) ? 23'h0 : 23'($urandom);
      n   = $urandom_range(200, 1);
      ei  = $urandom_range(7);
      build_model(sel, sd, n);
      do_start(sel, sd, n, ei);
      run(2000, 70, -1);
      verify_run($sformatf("random %0d", k), n, ei);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_pattern_gen.md
# ber_pattern_gen

Transmit-side stimulus source for the link BER test path. Generates a PRBS payload of programmable length, optionally injects deterministic bit flips, and drives it into the convolutional encoder over a valid/ready handshake. Appends TB_LEN zero tail symbols to flush the decoder. Mirrors each clean payload bit onto a reference stream (ref_valid/ref_bit/advance) that feeds the receive-side BER checker, so the checker's error count equals the number of injected flips.

## Interface
- TB_LEN, 12: number of zero tail symbols after the payload; must equal the checker's traceback depth.
- clk  in  1  single clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a run when state is IDLE or DONE, ignored otherwise
- total_bits  in  16  payload length, latched on accepted start
- prbs_sel  in  2  pattern, latched on start: 0 PRBS7 (x^7+x^6+1), 1 PRBS15 (x^15+x^14+1), 2 PRBS23 (x^23+x^18+1), 3 alternating 1,0,1,0…
- seed  in  23  LFSR seed, latched on start; low bits used per width; all-zero seed is replaced by all-ones
- err_interval  in  16  flip every Nth payload bit on tx_bit only; 0 disables; latched on start
- tx_valid  out  1  symbol available to encoder
- tx_bit  out  1  symbol to encoder (payload, possibly flipped, then zeros)
- tx_ready  in  1  encoder accepts symbol
- ref_valid  out  1  high on payload transfer cycles only
- ref_bit  out  1  clean (unflipped) payload bit, meaningful when ref_valid
- advance  out  1  equals tx_valid & tx_ready (payload and tail)
- busy  out  1  state is PAYLOAD or TAIL
- done  out  1  level, high in DONE until next accepted start or reset
- bits_sent  out  32  payload bits transferred this run
- errors_injected  out  32  flips applied this run

## Operation
- States: IDLE, PAYLOAD, TAIL, DONE.
- IDLE/DONE + start: latch config, load LFSR, clear counters/done. If total_bits==0, go to DONE (no transfers). Otherwise go to PAYLOAD.
- PAYLOAD: tx_valid=1. Transfer = tx_valid & tx_ready. Each transfer advances the pattern once, increments bits_sent and the interval counter. On the transfer where bits_sent+1==total_bits, go to TAIL.
- TAIL: tx_valid=1, tx_bit=0, ref_valid=0. After TB_LEN transfers, go to DONE.
- LFSR is Fibonacci. fb = XOR of the two tap bits (PRBS7 [6]^[5], PRBS15 [14]^[13], PRBS23 [22]^[17]). Shift left with fb into bit 0. The payload bit is fb.
  - PRBS7 from seed 0x7F gives 0,0,0,0,0,0,1 as its first seven bits. Period 127.
  - Alternating mode starts with 1.
- Injection: the interval counter counts payload transfers. On the transfer where the count reaches err_interval, invert tx_bit (ref_bit stays clean), increment errors_injected, and clear the count. Flipped 0-based indices are err_interval-1, 2·err_interval-1, …
- Counters saturate at 0xFFFFFFFF.

## Timing
- Reset values: tx_valid 0, tx_bit 0, ref_valid 0, ref_bit 0, advance 0, busy 0, done 0, bits_sent 0, errors_injected 0, state IDLE.
- Start accepted in cycle N gives tx_valid=1 in cycle N+1 (registered outputs).
- tx_bit, ref_bit and the LFSR stay stable while tx_valid & !tx_ready; back-to-back transfers occur at one per cycle when tx_ready is held high.
- advance, ref_valid and ref_bit are combinational from the registered tx_valid and tx_bit plus tx_ready, so they line up with the transfer cycle.
- done rises the cycle after the last tail transfer. busy falls in the same cycle.
- start while busy: ignored, with no effect on config or counters.
- rst mid-run: all state returns to reset values next cycle, and the run is abandoned.

## Structure
- Package ber_pkg: PRBS select codes, tap positions per polynomial, LFSR width 23.
- Sub-module prbs_lfsr: width-23 register plus tap muxing. Inputs: load, seed, sel, step. Output: bit.
- Top level holds the FSM, handshake, injection counter and statistics.

## Test plan
- PRBS7, seed 0x7F, total_bits 7, err_interval 0, tx_ready=1:
  - tx_bit payload is 0,0,0,0,0,0,1, followed by 12 zeros.
  - advance high 19 cycles; ref_valid high 7.
  - done high, bits_sent 7, errors_injected 0.
- PRBS15, total_bits 100, err_interval 10:
  - tx_bit differs from ref_bit exactly at indices 9,19,…,99.
  - errors_injected 10.
- Random tx_ready with ~50% stalls, PRBS23, total_bits 1000:
  - tx_bit and the LFSR are held across stalls.
  - Captured stream matches a software PRBS23 model; advance count 1012.
- total_bits 0: done the cycle after start, no advance, bits_sent 0.
- Start pulsed mid-PAYLOAD is ignored. rst asserted mid-TAIL returns all outputs to reset values next cycle; a new start then runs normally.
- prbs_sel 3, total_bits 4: payload 1,0,1,0.
